// File: rtl/id_stream_gen_if.sv
// rtl/id_stream_gen_if.sv - command, status and character-stream bundle for id_stream_gen
interface id_stream_gen_if;
   logic       start;
   logic [3:0] letter_cnt;
   logic [3:0] digit_cnt;
   logic [4:0] first_letter;
   logic       upper;
   logic [7:0] char;
   logic       char_valid;
   logic       char_ready;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      input  start, letter_cnt, digit_cnt, first_letter, upper, char_ready,
      output char, char_valid, busy, done, err
   );

   modport slave (
      output start, letter_cnt, digit_cnt, first_letter, upper, char_ready,
      input  char, char_valid, busy, done, err
   );
endinterface

// File: rtl/id_stream_gen.sv
// rtl/id_stream_gen.sv - emits one identifier token (letters, digits, space) per accepted start
module id_stream_gen (
   input logic             clk,
   input logic             rst_n,
   id_stream_gen_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_LETTER, S_DIGIT, S_SEP, S_FIN} state_t;

   state_t     state_q, state_d;
   logic [7:0] char_q, char_d;
   logic       valid_q, valid_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic [3:0] cnt_q, cnt_d;
   logic [4:0] idx_q, idx_d;
   logic [3:0] digit_q, digit_d;
   logic [3:0] dcnt_q, dcnt_d;
   logic       upper_q, upper_d;

   logic       xfer;
   logic [4:0] idx_nxt;
   logic [3:0] digit_nxt;

   function automatic logic [7:0] letter_code(input logic up, input logic [4:0] idx);
      return (up ? 8'd65 : 8'd97) + {3'b000, idx};
   endfunction

   assign xfer      = valid_q & bus.char_ready;
   assign idx_nxt   = (idx_q == 5'd25) ? 5'd0 : idx_q + 5'd1;
   assign digit_nxt = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;

   // cnt_q counts characters still to transfer in the current field, including the one on offer
   always_comb begin
      state_d = state_q;
      char_d  = char_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      digit_d = digit_q;
      dcnt_d  = dcnt_q;
      upper_d = upper_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.letter_cnt != 4'd0 && bus.first_letter <= 5'd25) begin
                  state_d = S_LETTER;
                  upper_d = bus.upper;
                  dcnt_d  = bus.digit_cnt;
                  cnt_d   = bus.letter_cnt;
                  idx_d   = bus.first_letter;
                  digit_d = 4'd0;
                  valid_d = 1'b1;
                  char_d  = letter_code(bus.upper, bus.first_letter);
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LETTER: begin
            if (xfer) begin
               if (cnt_q == 4'd1) begin
                  if (dcnt_q != 4'd0) begin
                     state_d = S_DIGIT;
                     cnt_d   = dcnt_q;
                     digit_d = 4'd0;
                     char_d  = 8'd48;
                  end else begin
                     state_d = S_SEP;
                     cnt_d   = 4'd0;
                     char_d  = 8'd32;
                  end
               end else begin
                  cnt_d  = cnt_q - 4'd1;
                  idx_d  = idx_nxt;
                  char_d = letter_code(upper_q, idx_nxt);
               end
            end
         end
         S_DIGIT: begin
            if (xfer) begin
               if (cnt_q == 4'd1) begin
                  state_d = S_SEP;
                  cnt_d   = 4'd0;
                  char_d  = 8'd32;
               end else begin
                  cnt_d   = cnt_q - 4'd1;
                  digit_d = digit_nxt;
                  char_d  = 8'd48 + {4'b0000, digit_nxt};
               end
            end
         end
         S_SEP: begin
            if (xfer) begin
               state_d = S_FIN;
               valid_d = 1'b0;
               char_d  = 8'd0;
               done_d  = 1'b1;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            char_d  = 8'd0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         char_q  <= 8'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= 4'd0;
         idx_q   <= 5'd0;
         digit_q <= 4'd0;
         dcnt_q  <= 4'd0;
         upper_q <= 1'b0;
      end else begin
         state_q <= state_d;
         char_q  <= char_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         digit_q <= digit_d;
         dcnt_q  <= dcnt_d;
         upper_q <= upper_d;
      end
   end

   assign bus.char       = char_q;
   assign bus.char_valid = valid_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
endmodule

// File: tb/tb_id_stream_gen.sv
// tb/tb_id_stream_gen.sv - directed self-checking bench for id_stream_gen
module tb_id_stream_gen;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   id_stream_gen_if bus ();

   id_stream_gen dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue start for one cycle (or leave it high), then scramble the parameters.
   task automatic send_start(input int l, input int d, input int f, input bit u, input bit hold);
      bus.letter_cnt   = 4'(l);
      bus.digit_cnt    = 4'(d);
      bus.first_letter = 5'(f);
      bus.upper        = u;
      bus.start        = 1'b1;
      tick();
      if (!hold) bus.start = 1'b0;
      bus.letter_cnt   = 4'd7;
      bus.digit_cnt    = 4'd9;
      bus.first_letter = 5'd13;
      bus.upper        = ~u;
   endtask

   // Called at the sample point right after the start edge; ends one cycle after FIN.
   task automatic run_stream(input string tag, input int exp[$], input bit toggle);
      int  k;
      int  cyc;
      bit  stalled;
      int  held;
      k = 0;
      cyc = 0;
      stalled = 1'b0;
      held = 0;
      bus.char_ready = 1'b1;
      while (k < exp.size() && cyc < 200) begin
         if (stalled) begin
            chk({tag, " hold_char"}, int'(bus.char), held);
            chk({tag, " hold_valid"}, int'(bus.char_valid), 1);
         end
         bus.char_ready = toggle ? ~bus.char_ready : 1'b1;
         stalled = 1'b0;
         if (bus.char_valid && bus.char_ready) begin
            chk($sformatf("%s char[%0d]", tag, k), int'(bus.char), exp[k]);
            k++;
         end else if (bus.char_valid) begin
            stalled = 1'b1;
            held = int'(bus.char);
         end
         tick();
         cyc++;
      end
      chk({tag, " count"}, k, exp.size());
      if (!toggle) chk({tag, " no_bubbles"}, cyc, exp.size());
      chk({tag, " fin_done"}, int'(bus.done), 1);
      chk({tag, " fin_valid"}, int'(bus.char_valid), 0);
      chk({tag, " fin_char"}, int'(bus.char), 0);
      chk({tag, " fin_busy"}, int'(bus.busy), 1);
      tick();
      chk({tag, " idle_busy"}, int'(bus.busy), 0);
      chk({tag, " idle_done"}, int'(bus.done), 0);
      chk({tag, " idle_valid"}, int'(bus.char_valid), 0);
   endtask

   initial begin
      int q[$];
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.letter_cnt = 4'd0;
      bus.digit_cnt = 4'd0;
      bus.first_letter = 5'd0;
      bus.upper = 1'b0;
      bus.char_ready = 1'b1;
      tick();
      tick();
      chk("rst char", int'(bus.char), 0);
      chk("rst valid", int'(bus.char_valid), 0);
      chk("rst busy", int'(bus.busy), 0);
      chk("rst done", int'(bus.done), 0);
      chk("rst err", int'(bus.err), 0);
      rst_n = 1'b1;
      tick();

      // uppercase, two letters, three digits
      send_start(2, 3, 0, 1'b1, 1'b0);
      q = '{65, 66, 48, 49, 50, 32};
      run_stream("t029", q, 1'b0);

      // letter and digit wrap
      send_start(3, 12, 24, 1'b0, 1'b0);
      q = '{121, 122, 97, 48, 49, 50, 51, 52, 53, 54, 55, 56, 57, 48, 49, 32};
      run_stream("t030", q, 1'b0);

      // backpressure toggling each cycle
      send_start(1, 0, 3, 1'b0, 1'b0);
      q = '{100, 32};
      run_stream("t031", q, 1'b1);
      bus.char_ready = 1'b1;

      // rejected starts
      send_start(0, 2, 0, 1'b0, 1'b0);
      chk("t032a err", int'(bus.err), 1);
      chk("t032a busy", int'(bus.busy), 0);
      chk("t032a valid", int'(bus.char_valid), 0);
      tick();
      chk("t032a err_pulse", int'(bus.err), 0);
      chk("t032a idle_busy", int'(bus.busy), 0);
      send_start(2, 2, 30, 1'b0, 1'b0);
      chk("t032b err", int'(bus.err), 1);
      chk("t032b busy", int'(bus.busy), 0);
      chk("t032b valid", int'(bus.char_valid), 0);
      tick();
      chk("t032b err_pulse", int'(bus.err), 0);

      // asynchronous reset in the middle of the digit field
      send_start(1, 5, 0, 1'b0, 1'b0);
      chk("t033 first", int'(bus.char), 97);
      tick();
      chk("t033 digit0", int'(bus.char), 48);
      tick();
      chk("t033 digit1", int'(bus.char), 49);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t033 async_char", int'(bus.char), 0);
      chk("t033 async_valid", int'(bus.char_valid), 0);
      chk("t033 async_busy", int'(bus.busy), 0);
      chk("t033 async_done", int'(bus.done), 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("t033 no_done", int'(bus.done), 0);
      chk("t033 post_busy", int'(bus.busy), 0);
      send_start(2, 1, 25, 1'b1, 1'b0);
      q = '{90, 65, 48, 32};
      run_stream("t033 resume", q, 1'b0);

      // start held high across a whole token
      send_start(1, 0, 1, 1'b0, 1'b1);
      q = '{98, 32};
      run_stream("t034 first", q, 1'b0);
      bus.letter_cnt = 4'd1;
      bus.digit_cnt = 4'd0;
      bus.first_letter = 5'd1;
      bus.upper = 1'b0;
      tick();
      bus.start = 1'b0;
      chk("t034 restart_valid", int'(bus.char_valid), 1);
      run_stream("t034 second", q, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/id_stream_gen.md
ID_STREAM_GEN -- requirements
Module: id_stream_gen

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  request to emit one identifier token; sampled only in IDLE.
REQ-004 letter_cnt  input  4  number of letters in the token, legal range 1-15.
REQ-005 digit_cnt  input  4  number of digits following the letters, range 0-15.
REQ-006 first_letter  input  5  index of the first letter, 0-25 (0='a'/'A').
REQ-007 upper  input  1  1 selects uppercase letters ('A'=65), 0 selects lowercase ('a'=97).
REQ-008 char  output  8  ASCII character currently offered.
REQ-009 char_valid  output  1  char is valid this cycle.
REQ-010 char_ready  input  1  consumer accepts char; a transfer occurs when char_valid and char_ready are both 1 at a rising edge.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse after the final transfer of a token.
REQ-013 err  output  1  one-cycle pulse when start is rejected for bad parameters.

Function
REQ-014 States SHALL be IDLE, LETTER, DIGIT, SEP, FIN; all outputs registered.
REQ-015 In IDLE with start=1 and letter_cnt>=1 and first_letter<=25, the block SHALL capture all parameters and enter LETTER; char_valid rises the next cycle (1-cycle start latency).
REQ-016 In IDLE with start=1 and letter_cnt=0 or first_letter>25, the block SHALL stay in IDLE and pulse err for exactly one cycle.
REQ-017 start SHALL be ignored in every state other than IDLE; parameter changes after capture SHALL have no effect.
REQ-018 LETTER SHALL emit letter_cnt letters, first = base+first_letter, each next letter index +1, wrapping 25->0 ('z'->'a', 'Z'->'A').
REQ-019 After the last letter transfer: digit_cnt>0 -> DIGIT, else -> SEP.
REQ-020 DIGIT SHALL emit digit_cnt digits starting at '0' (48), incrementing, wrapping '9'->'0'.
REQ-021 After the last digit transfer -> SEP; SEP SHALL emit one space (32).
REQ-022 On the SEP transfer the block SHALL enter FIN, drop char_valid, pulse done for one cycle, then return to IDLE the following cycle.
REQ-023 While char_valid=1 and char_ready=0, char SHALL hold stable and no counter or state SHALL advance (unbounded stall allowed).
REQ-024 With char_ready held 1, the block SHALL emit one character per cycle with no bubbles; total token cycles from start = 1 + letter_cnt + digit_cnt + 1, done in the next cycle.
REQ-025 char_valid SHALL never be 1 in IDLE or FIN; char is don't-care-free: it SHALL read 0 whenever char_valid=0.
REQ-026 done and err SHALL never be high in the same cycle.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, char=0, char_valid=0, busy=0, done=0, err=0, internal counters=0, independent of clk.
REQ-028 Reset mid-token SHALL abandon the token with no done pulse; after rst_n returns to 1 the first start is processed normally.

Verification
REQ-029 start, letter_cnt=2, digit_cnt=3, first_letter=0, upper=1, ready=1 -> chars 65,66,48,49,50,32 on consecutive cycles, then done pulse, busy low next cycle.
REQ-030 letter_cnt=3, first_letter=24, upper=0, digit_cnt=12, ready=1 -> 121,122,97 then 48..57,48,49 then 32 (letter and digit wrap).
REQ-031 letter_cnt=1, digit_cnt=0, first_letter=3, ready toggling 0/1 each cycle -> 'd'(100) held until accepted, then 32, no duplicates, no drops.
REQ-032 start with letter_cnt=0, then start with first_letter=30 -> err pulse each time, busy stays 0, char_valid stays 0.
REQ-033 rst_n pulled low during DIGIT -> outputs zero asynchronously, no done; new start after release yields a correct full token.
REQ-034 start asserted continuously through a token -> second token begins only after return to IDLE (one idle cycle after done).
